// File: rtl/alu_pkg.sv
// Shared definitions for the registered 4-bit ALU: opcode encodings and the
// compare-flag derivation from the subtractor result.
package alu_pkg;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_ADD = 2'b00;
    localparam opcode_t OP_SUB = 2'b01;
    localparam opcode_t OP_CMP = 2'b10;
    localparam opcode_t OP_AND = 2'b11;

    // Flags are returned as {agb, aeb, alb}. The carry comes from A + ~B + 1,
    // so it is 1 exactly when A >= B.
    function automatic logic [2:0] cmp_flags(input logic [3:0] diff, input logic carry);
        logic aeb;
        aeb = (diff == 4'b0000);
        return {carry & ~aeb, aeb, ~carry};
    endfunction

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder.
// It is built from four full-adder bit slices.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];

endmodule

// File: rtl/four_bit_alu.sv
// Registered 4-bit unsigned ALU. The opcode selects which output group loads
// on each clock edge. Groups that are not selected hold their last value.
module four_bit_alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] S,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Y_add,
    output logic       carry_add,
    output logic [3:0] Y_sub,
    output logic       carry_sub,
    output logic [3:0] Y_and,
    output logic       AGB,
    output logic       AEB,
    output logic       ALB
);

    logic [3:0] adder_b;
    logic       adder_cin;
    logic [3:0] adder_sum;
    logic       adder_cout;
    logic [2:0] flags;
    logic [3:0] and_val;

    // Subtract and compare both use A + ~B + 1. Only add uses B directly.
    assign adder_b   = (S == OP_ADD) ? B : ~B;
    assign adder_cin = (S != OP_ADD);

    rca4 u_rca4 (
        .a    (A),
        .b    (adder_b),
        .cin  (adder_cin),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    assign flags   = cmp_flags(adder_sum, adder_cout);
    assign and_val = A & B;

    always_ff @(posedge clk) begin
        if (rst) begin
            Y_add     <= 4'b0000;
            carry_add <= 1'b0;
            Y_sub     <= 4'b0000;
            carry_sub <= 1'b0;
            Y_and     <= 4'b0000;
            AGB       <= 1'b0;
            AEB       <= 1'b0;
            ALB       <= 1'b0;
        end else begin
            case (S)
                OP_ADD:  {carry_add, Y_add} <= {adder_cout, adder_sum};
                OP_SUB:  {carry_sub, Y_sub} <= {adder_cout, adder_sum};
                OP_CMP:  {AGB, AEB, ALB}    <= flags;
                default: Y_and              <= and_val;
            endcase
        end
    end

endmodule

// File: tb/tb_four_bit_alu.sv
// Directed and exhaustive check of four_bit_alu against hand-computed values
// and a behavioural shadow model of the output registers.
module tb_four_bit_alu;

    logic       clk;
    logic       rst;
    logic [1:0] S;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Y_add;
    logic       carry_add;
    logic [3:0] Y_sub;
    logic       carry_sub;
    logic [3:0] Y_and;
    logic       AGB;
    logic       AEB;
    logic       ALB;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_add;
    logic [4:0] m_sub;
    logic [3:0] m_and;
    logic [2:0] m_cmp;

    four_bit_alu dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .A         (A),
        .B         (B),
        .Y_add     (Y_add),
        .carry_add (carry_add),
        .Y_sub     (Y_sub),
        .carry_sub (carry_sub),
        .Y_and     (Y_and),
        .AGB       (AGB),
        .AEB       (AEB),
        .ALB       (ALB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] dut_vec();
        return {carry_add, Y_add, carry_sub, Y_sub, Y_and, AGB, AEB, ALB};
    endfunction

    task automatic check_val(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operation, clock it in, update the shadow model, then settle
    // on the falling edge so outputs are sampled away from the active edge.
    task automatic step(input logic r, input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        rst = r;
        S   = s;
        A   = a;
        B   = b;
        @(posedge clk);
        if (r) begin
            m_add = 5'd0;
            m_sub = 5'd0;
            m_and = 4'd0;
            m_cmp = 3'd0;
        end else begin
            case (s)
                2'b00: m_add = {1'b0, a} + {1'b0, b};
                2'b01: m_sub = {(a >= b), 4'(a - b)};
                2'b10: m_cmp = {(a > b), (a == b), (a < b)};
                default: m_and = a & b;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        S   = 2'($urandom);
        A   = 4'($urandom);
        B   = 4'($urandom);
        m_add = 5'd0;
        m_sub = 5'd0;
        m_and = 4'd0;
        m_cmp = 3'd0;

        step(1'b1, 2'($urandom), 4'($urandom), 4'($urandom));
        step(1'b1, 2'($urandom), 4'($urandom), 4'($urandom));
        check_val("reset_all", dut_vec(), 17'd0);

        step(1'b0, 2'b00, 4'b0000, 4'b0000);
        check_val("add_zero", 17'({carry_add, Y_add}), 17'(5'b0_0000));
        check_val("cmp_after_reset", 17'({AGB, AEB, ALB}), 17'(3'b000));

        step(1'b0, 2'b00, 4'b1110, 4'b0001);
        check_val("add_e_1", 17'({carry_add, Y_add}), 17'(5'b0_1111));
        step(1'b0, 2'b00, 4'b1111, 4'b0001);
        check_val("add_wrap", 17'({carry_add, Y_add}), 17'(5'b1_0000));

        step(1'b0, 2'b01, 4'b1010, 4'b0011);
        check_val("sub_a_3", 17'({carry_sub, Y_sub}), 17'(5'b1_0111));
        check_val("add_hold1", 17'({carry_add, Y_add}), 17'(5'b1_0000));
        step(1'b0, 2'b01, 4'b0011, 4'b1010);
        check_val("sub_borrow", 17'({carry_sub, Y_sub}), 17'(5'b0_1001));
        check_val("add_hold2", 17'({carry_add, Y_add}), 17'(5'b1_0000));
        step(1'b0, 2'b01, 4'b0000, 4'b0001);
        check_val("sub_wrap", 17'({carry_sub, Y_sub}), 17'(5'b0_1111));

        step(1'b0, 2'b10, 4'b1010, 4'b0011);
        check_val("cmp_gt", 17'({AGB, AEB, ALB}), 17'(3'b100));
        step(1'b0, 2'b10, 4'b0110, 4'b0110);
        check_val("cmp_eq", 17'({AGB, AEB, ALB}), 17'(3'b010));
        step(1'b0, 2'b10, 4'b0000, 4'b1111);
        check_val("cmp_lt", 17'({AGB, AEB, ALB}), 17'(3'b001));

        step(1'b0, 2'b11, 4'b1010, 4'b0011);
        check_val("and_a_3", 17'(Y_and), 17'(4'b0010));
        check_val("and_cmp_hold", 17'({AGB, AEB, ALB}), 17'(3'b001));
        check_val("and_sub_hold", 17'({carry_sub, Y_sub}), 17'(5'b0_1111));

        step(1'b0, 2'b00, 4'b0011, 4'b0100);
        check_val("add_pre_rst", 17'({carry_add, Y_add}), 17'(5'b0_0111));
        step(1'b1, 2'b01, 4'b1001, 4'b0010);
        check_val("mid_reset", dut_vec(), 17'd0);

        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    step(1'b0, 2'(s), 4'(a), 4'(b));
                    check_val("sweep", dut_vec(), {m_add, m_sub, m_and, m_cmp});
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
